// File: rtl/controle_multiciclo_if.sv
// Bundle of the controller <-> datapath/memory signals of the multicycle control unit.
//   master : the control unit (consumes iOpcode/iMemPronta, drives every o* signal)
//   slave  : datapath / memory side (the reverse directions)
// Signals:
//   iOpcode[6:0]     opcode field of the instruction register (RV32I encodings)
//   iMemPronta       memory access completes this cycle
//   oEscrevePC/oEscreveIR/oIouD, oLeMem/oEscreveMem, oMem2Reg[1:0], oOrigULA, oALUOp[1:0],
//   oEscreveReg/oBranch/oJump  datapath controls
//   oEstado[2:0]     current state code
//   oFimInstr        retire pulse
//   oOpInvalido      error flag
//   oInstrConcluidas retired-instruction count (CONT_W bits)
interface controle_multiciclo_if #(
  parameter int unsigned CONT_W = 16
);
  logic [6:0]        iOpcode;
  logic              iMemPronta;
  logic              oEscrevePC;
  logic              oEscreveIR;
  logic              oIouD;
  logic              oLeMem;
  logic              oEscreveMem;
  logic [1:0]        oMem2Reg;
  logic              oOrigULA;
  logic [1:0]        oALUOp;
  logic              oEscreveReg;
  logic              oBranch;
  logic              oJump;
  logic [2:0]        oEstado;
  logic              oFimInstr;
  logic              oOpInvalido;
  logic [CONT_W-1:0] oInstrConcluidas;

  modport master (
    input  iOpcode, iMemPronta,
    output oEscrevePC, oEscreveIR, oIouD, oLeMem, oEscreveMem, oMem2Reg, oOrigULA, oALUOp,
           oEscreveReg, oBranch, oJump, oEstado, oFimInstr, oOpInvalido, oInstrConcluidas
  );

  modport slave (
    output iOpcode, iMemPronta,
    input  oEscrevePC, oEscreveIR, oIouD, oLeMem, oEscreveMem, oMem2Reg, oOrigULA, oALUOp,
           oEscreveReg, oBranch, oJump, oEstado, oFimInstr, oOpInvalido, oInstrConcluidas
  );
endinterface

// File: rtl/controle_multiciclo.sv
// Multicycle RV32I control unit: BUSCA -> DECOD -> EXEC -> [MEM] -> [ESCRITA] -> BUSCA,
// with a memory wait timeout into a sticky ERRO state and a retired-instruction counter.
// Ports:
//   iCLK  : clock, rising edge
//   iRSTn : synchronous active-low reset
//   bus   : controle_multiciclo_if.master (opcode/ready in, datapath controls out)
// Parameters:
//   USA_HANDSHAKE : 1 = memory states wait for iMemPronta, 0 = memory always ready
//   TIMEOUT_MEM   : wait cycles tolerated in BUSCA/MEM (1..255)
//   CONT_W        : width of the retired-instruction counter
module controle_multiciclo #(
  parameter bit          USA_HANDSHAKE = 1'b1,
  parameter int unsigned TIMEOUT_MEM   = 15,
  parameter int unsigned CONT_W        = 16
) (
  input logic                   iCLK,
  input logic                   iRSTn,
  controle_multiciclo_if.master bus
);

  typedef enum logic [2:0] {
    StBusca   = 3'd0,
    StDecod   = 3'd1,
    StExec    = 3'd2,
    StMem     = 3'd3,
    StEscrita = 3'd4,
    StErro    = 3'd5
  } estado_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;

  localparam logic [7:0] Limite = 8'(TIMEOUT_MEM);

  estado_e           estado_q, estado_d;
  logic [6:0]        opcode_q, opcode_d;
  logic [7:0]        espera_q, espera_d;
  logic [CONT_W-1:0] cont_q, cont_d;
  logic              pronto;

  logic       escreve_pc, escreve_ir, iou_d, le_mem, escreve_mem;
  logic [1:0] mem2reg, alu_op;
  logic       orig_ula, escreve_reg, branch, jump, fim, op_invalido;

  function automatic logic op_valido(input logic [6:0] op);
    case (op)
      OpLoad, OpStore, OpR, OpBranch, OpJal, OpJalr, OpImm, OpLui: return 1'b1;
      default:                                                     return 1'b0;
    endcase
  endfunction

  assign pronto = USA_HANDSHAKE ? bus.iMemPronta : 1'b1;

  // Next state. The wait counter defaults to zero, so it is cleared whenever
  // BUSCA or MEM is entered and only counts while a memory state holds.
  always_comb begin
    estado_d = estado_q;
    opcode_d = opcode_q;
    espera_d = '0;
    cont_d   = cont_q;
    case (estado_q)
      StBusca: begin
        if (pronto)                   estado_d = StDecod;
        else if (espera_q == Limite)  estado_d = StErro;
        else                          espera_d = espera_q + 8'd1;
      end
      StDecod: begin
        opcode_d = bus.iOpcode;
        estado_d = op_valido(bus.iOpcode) ? StExec : StErro;
      end
      StExec: begin
        case (opcode_q)
          OpLoad, OpStore:          estado_d = StMem;
          OpR, OpImm, OpLui:        estado_d = StEscrita;
          OpBranch, OpJal, OpJalr:  estado_d = StBusca;
          default:                  estado_d = StErro;
        endcase
      end
      StMem: begin
        if (pronto)                   estado_d = (opcode_q == OpLoad) ? StEscrita : StBusca;
        else if (espera_q == Limite)  estado_d = StErro;
        else                          espera_d = espera_q + 8'd1;
      end
      StEscrita: estado_d = StBusca;
      StErro:    estado_d = StErro;
      default:   estado_d = StErro;
    endcase
    if (fim) cont_d = cont_q + 1'b1;
  end

  always_ff @(posedge iCLK) begin
    if (!iRSTn) begin
      estado_q <= StBusca;
      opcode_q <= '0;
      espera_q <= '0;
      cont_q   <= '0;
    end else begin
      estado_q <= estado_d;
      opcode_q <= opcode_d;
      espera_q <= espera_d;
      cont_q   <= cont_d;
    end
  end

  // Datapath controls decoded from the state and the latched opcode.
  always_comb begin
    escreve_pc  = 1'b0;
    escreve_ir  = 1'b0;
    iou_d       = 1'b0;
    le_mem      = 1'b0;
    escreve_mem = 1'b0;
    mem2reg     = 2'b00;
    orig_ula    = 1'b0;
    alu_op      = 2'b00;
    escreve_reg = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    fim         = 1'b0;
    op_invalido = 1'b0;
    case (estado_q)
      StBusca: begin
        le_mem     = 1'b1;
        escreve_ir = pronto;
        escreve_pc = pronto;
      end
      StExec: begin
        case (opcode_q)
          OpLoad, OpStore, OpImm: orig_ula = 1'b1;
          OpR:                    alu_op = 2'b10;
          OpLui: begin
            orig_ula = 1'b1;
            alu_op   = 2'b11;
          end
          OpBranch: begin
            branch = 1'b1;
            alu_op = 2'b01;
            fim    = 1'b1;
          end
          OpJal, OpJalr: begin
            jump        = 1'b1;
            escreve_reg = 1'b1;
            mem2reg     = 2'b10;
            escreve_pc  = 1'b1;
            orig_ula    = (opcode_q == OpJalr);
            fim         = 1'b1;
          end
          default: ;
        endcase
      end
      StMem: begin
        iou_d       = 1'b1;
        le_mem      = (opcode_q == OpLoad);
        escreve_mem = (opcode_q == OpStore);
        fim         = pronto && (opcode_q == OpStore);
      end
      StEscrita: begin
        escreve_reg = 1'b1;
        mem2reg     = (opcode_q == OpLoad) ? 2'b01 : 2'b00;
        fim         = 1'b1;
      end
      StErro:  op_invalido = 1'b1;
      default: ;
    endcase
  end

  // Controls are forced low while reset is held so the first fetch request
  // appears only once iRSTn has returned high.
  assign bus.oEscrevePC       = escreve_pc & iRSTn;
  assign bus.oEscreveIR       = escreve_ir & iRSTn;
  assign bus.oIouD            = iou_d & iRSTn;
  assign bus.oLeMem           = le_mem & iRSTn;
  assign bus.oEscreveMem      = escreve_mem & iRSTn;
  assign bus.oMem2Reg         = mem2reg & {2{iRSTn}};
  assign bus.oOrigULA         = orig_ula & iRSTn;
  assign bus.oALUOp           = alu_op & {2{iRSTn}};
  assign bus.oEscreveReg      = escreve_reg & iRSTn;
  assign bus.oBranch          = branch & iRSTn;
  assign bus.oJump            = jump & iRSTn;
  assign bus.oFimInstr        = fim & iRSTn;
  assign bus.oOpInvalido      = op_invalido & iRSTn;
  assign bus.oEstado          = estado_q;
  assign bus.oInstrConcluidas = cont_q;

endmodule
